board_cell_locator: RTL and testbench
=====================================

// Module: board_cell_locator
// PURPOSE
//  Upstream stage of every per-cell board bitmap (mine, flag, number, covered tile). Tracks the VGA raster
//  with pixel/line counters instead of dividers and reports, per pixel, whether it lies on the board. If so,
//  it also reports the cell column/row and the 0..31 offset inside that cell. Feeds offset_x/offset_y/
//  inside_rectangle of the bitmap stages and cell_col/cell_row to the board-state RAM address logic.
// PARAMETERS
//  LEFT_X      64   first board pixel column (screen x)
//  TOP_Y       32   first board pixel row (screen y)
//  COLS        16   board width in cells, 1..64
//  ROWS        12   board height in cells, 1..64
//  CELL_BITS   5    log2 of cell edge; cell is 32x32 px
// PORTS
//  clk              in   1   system clock
//  rst_n            in   1   async reset, active low
//  pixel_x          in   11  current raster x
//  pixel_y          in   11  current raster y
//  pixel_valid      in   1   pixel_x/pixel_y valid this cycle; raster advances one pixel per valid
//  start_of_frame   in   1   one-cycle pulse before the first pixel of a frame
//  offset_x         out  11  x offset inside cell, zero-extended, 0..31
//  offset_y         out  11  y offset inside cell, zero-extended, 0..31
//  cell_col         out  6   cell column, 0..COLS-1
//  cell_row         out  6   cell row, 0..ROWS-1
//  inside_rectangle out  1   pixel lies on the board
//  sync_error       out  1   sticky: raster did not match internal counters
// BEHAVIOUR
//  Clocking: one clock (clk). Reset is rst_n: asynchronous assert, active low.
//  Reset: all outputs 0; x_act=y_act=0; all counters 0; last_y=0.
//  Latency: all outputs are registered. They describe the pixel sampled with pixel_valid at edge N and
//   appear after edge N. No update when pixel_valid=0; outputs hold.
//  X tracker (on pixel_valid):
//   - pixel_x==LEFT_X -> x_act=1, x_off=0, col=0.
//   - else if x_act and x_off==31:
//     - col==COLS-1 -> x_act=0.
//     - otherwise col++, x_off=0.
//   - else if x_act -> x_off++.
//  Y tracker (evaluated on pixel_valid && pixel_x==LEFT_X, once per line):
//   - pixel_y==TOP_Y -> y_act=1, y_off=0, row=0.
//   - else if y_act and pixel_y!=last_y: if y_off==31 { row==ROWS-1 ? y_act=0 : row++, y_off=0 } else y_off++.
//   - last_y<=pixel_y.
//  start_of_frame: clears y_act and x_act. It takes priority over a simultaneous pixel_valid.
//  Outputs: inside_rectangle = x_act_next & y_act_next. offset/cell outputs carry the next counter values.
//   When inside_rectangle=0 they are forced to 0.
//  Board end: right edge is pixel LEFT_X+32*COLS-1 (inside=1). The next pixel has inside=0.
//   Bottom edge behaves the same way with rows.
//  sync_error: set when x_act and pixel_valid and pixel_x != LEFT_X+32*col+x_off+1. This means the raster
//   skipped or stalled. Cleared only by start_of_frame or reset.
//  Reset mid-line: trackers idle until the next pixel_x==LEFT_X on a line where pixel_y==TOP_Y. No spurious
//   inside_rectangle.
//  Arithmetic: counters wrap only as described. Comparisons use 11-bit unsigned values.
//   LEFT_X+32*COLS and TOP_Y+32*ROWS must be <=2047.
// CONFIGURATION
//  GRID_GAP_EN defined: pixels with x_off==0 or y_off==0 report inside_rectangle=0. This draws a 1-px grid
//   line between cells. offset and cell outputs are still 0 there; counters are unaffected.
//  GRID_GAP_EN undefined: every board pixel reports inside_rectangle=1.
// TESTING
//  1. Reset, then raster (64,32) valid -> next cycle inside=1, offset=(0,0), cell=(0,0), sync_error=0.
//  2. Same line, pixel_x=95 then 96 -> offset_x 31/col 0, then offset_x 0/col 1.
//  3. Line y=64, pixel_x=64+32*16-1=575 then 576 -> inside 1 (col 15, off 31), then 0.
//  4. Lines y=415 then y=416 -> row 11 off 31, then inside=0. Next frame y=32 restarts at row 0.
//  5. Skip pixel_x 100->102 mid-board -> sync_error=1 and holds. start_of_frame -> sync_error=0.
//  6. GRID_GAP_EN: pixel (96,33) -> inside=0. Pixel (97,33) -> inside=1, offset=(1,1), col 1.

Source files
------------

// File: rtl/board_cell_locator.sv
// Raster-tracking board locator: per pixel reports board membership, cell col/row and in-cell offset.
// Optional GRID_GAP_EN: blank the first pixel row/column of every cell to draw a 1-px grid.
module board_cell_locator #(
    parameter int LEFT_X    = 64,
    parameter int TOP_Y     = 32,
    parameter int COLS      = 16,
    parameter int ROWS      = 12,
    parameter int CELL_BITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic        pixel_valid,
    input  logic        start_of_frame,
    output logic [10:0] offset_x,
    output logic [10:0] offset_y,
    output logic [5:0]  cell_col,
    output logic [5:0]  cell_row,
    output logic        inside_rectangle,
    output logic        sync_error
);
    logic                 r_x_act, r_y_act, r_sync;
    logic [CELL_BITS-1:0] r_x_off, r_y_off;
    logic [5:0]           r_col, r_row;
    logic [10:0]          r_last_y;

    logic                 w_x_act, w_y_act, w_sync, w_inside, w_upd;
    logic [CELL_BITS-1:0] w_x_off, w_y_off;
    logic [5:0]           w_col, w_row;
    logic [10:0]          w_last_y, w_expect_x;

    // Where the raster should be if it advanced by exactly one pixel since the last valid.
    assign w_expect_x = 11'(LEFT_X) + (11'(r_col) << CELL_BITS) + 11'(r_x_off) + 11'd1;
    assign w_upd      = start_of_frame | pixel_valid;

    always_comb begin
        w_x_act  = r_x_act;
        w_x_off  = r_x_off;
        w_col    = r_col;
        w_y_act  = r_y_act;
        w_y_off  = r_y_off;
        w_row    = r_row;
        w_last_y = r_last_y;
        w_sync   = r_sync;
        if (start_of_frame) begin
            w_x_act = 1'b0;
            w_y_act = 1'b0;
            w_sync  = 1'b0;
        end else if (pixel_valid) begin
            if (pixel_x == 11'(LEFT_X)) begin
                w_x_act = 1'b1;
                w_x_off = '0;
                w_col   = '0;
            end else if (r_x_act && r_x_off == '1) begin
                if (r_col == 6'(COLS - 1)) begin
                    w_x_act = 1'b0;
                end else begin
                    w_col   = r_col + 6'd1;
                    w_x_off = '0;
                end
            end else if (r_x_act) begin
                w_x_off = r_x_off + 1'b1;
            end

            // Row tracking runs once per line, on the board's left-edge pixel.
            if (pixel_x == 11'(LEFT_X)) begin
                w_last_y = pixel_y;
                if (pixel_y == 11'(TOP_Y)) begin
                    w_y_act = 1'b1;
                    w_y_off = '0;
                    w_row   = '0;
                end else if (r_y_act && pixel_y != r_last_y) begin
                    if (r_y_off == '1) begin
                        if (r_row == 6'(ROWS - 1)) begin
                            w_y_act = 1'b0;
                        end else begin
                            w_row   = r_row + 6'd1;
                            w_y_off = '0;
                        end
                    end else begin
                        w_y_off = r_y_off + 1'b1;
                    end
                end
            end

            if (r_x_act && pixel_x != w_expect_x)
                w_sync = 1'b1;
        end
    end

    always_comb begin
`ifdef GRID_GAP_EN
        w_inside = w_x_act & w_y_act & (w_x_off != '0) & (w_y_off != '0);
`else
        w_inside = w_x_act & w_y_act;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_act          <= 1'b0;
            r_x_off          <= '0;
            r_col            <= '0;
            r_y_act          <= 1'b0;
            r_y_off          <= '0;
            r_row            <= '0;
            r_last_y         <= '0;
            r_sync           <= 1'b0;
            offset_x         <= '0;
            offset_y         <= '0;
            cell_col         <= '0;
            cell_row         <= '0;
            inside_rectangle <= 1'b0;
        end else if (w_upd) begin
            r_x_act          <= w_x_act;
            r_x_off          <= w_x_off;
            r_col            <= w_col;
            r_y_act          <= w_y_act;
            r_y_off          <= w_y_off;
            r_row            <= w_row;
            r_last_y         <= w_last_y;
            r_sync           <= w_sync;
            inside_rectangle <= w_inside;
            offset_x         <= w_inside ? 11'(w_x_off) : 11'd0;
            offset_y         <= w_inside ? 11'(w_y_off) : 11'd0;
            cell_col         <= w_inside ? w_col : 6'd0;
            cell_row         <= w_inside ? w_row : 6'd0;
        end
    end

    assign sync_error = r_sync;
endmodule

// File: tb/tb_board_cell_locator.sv
// Bench for board_cell_locator: vector table plus hand sequences, checked through an expectation queue.
module tb_board_cell_locator;
    typedef struct {
        logic [10:0] x, y;
        logic        v, sof;
        logic        ins;
        logic [10:0] ox, oy;
        logic [5:0]  col, row;
        logic        sync, chk_sync;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [10:0] pixel_x = '0, pixel_y = '0;
    logic        pixel_valid = 1'b0, start_of_frame = 1'b0;
    logic [10:0] offset_x, offset_y;
    logic [5:0]  cell_col, cell_row;
    logic        inside_rectangle, sync_error;

    int   total = 0, bad = 0;
    vec_t exp_q[$];
    vec_t tbl[$];
    vec_t last;

    always #5 clk = ~clk;

    board_cell_locator dut (
        .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_valid(pixel_valid), .start_of_frame(start_of_frame),
        .offset_x(offset_x), .offset_y(offset_y), .cell_col(cell_col), .cell_row(cell_row),
        .inside_rectangle(inside_rectangle), .sync_error(sync_error)
    );

    // Expected outputs for a pixel reached by an unbroken raster from the board origin.
    function automatic vec_t exp_at(input int x, input int y);
        vec_t e;
        int   dx = x - 64, dy = y - 32;
        logic onb = (x >= 64) && (x < 64 + 32 * 16) && (y >= 32) && (y < 32 + 32 * 12);
        e.x = 11'(x); e.y = 11'(y); e.v = 1'b1; e.sof = 1'b0;
        e.sync = 1'b0; e.chk_sync = 1'b0;
`ifdef GRID_GAP_EN
        if (onb && ((dx % 32) == 0 || (dy % 32) == 0)) onb = 1'b0;
`endif
        e.ins = onb;
        e.ox  = onb ? 11'(dx % 32) : 11'd0;
        e.oy  = onb ? 11'(dy % 32) : 11'd0;
        e.col = onb ? 6'(dx / 32) : 6'd0;
        e.row = onb ? 6'(dy / 32) : 6'd0;
        return e;
    endfunction

    function automatic vec_t blank(input int x, input int y, input logic v, input logic sof);
        vec_t e;
        e.x = 11'(x); e.y = 11'(y); e.v = v; e.sof = sof;
        e.ins = 1'b0; e.ox = '0; e.oy = '0; e.col = '0; e.row = '0;
        e.sync = 1'b0; e.chk_sync = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input vec_t e);
        total++;
        if (inside_rectangle !== e.ins || offset_x !== e.ox || offset_y !== e.oy ||
            cell_col !== e.col || cell_row !== e.row ||
            (e.chk_sync && sync_error !== e.sync)) begin
            bad++;
            $display("FAIL %s px=(%0d,%0d) got ins=%b off=(%0d,%0d) cell=(%0d,%0d) sync=%b want ins=%b off=(%0d,%0d) cell=(%0d,%0d) sync=%b(chk=%b)",
                     name, e.x, e.y, inside_rectangle, offset_x, offset_y, cell_col, cell_row, sync_error,
                     e.ins, e.ox, e.oy, e.col, e.row, e.sync, e.chk_sync);
        end
    endtask

    task automatic drive(input string name, input vec_t t);
        vec_t e;
        @(negedge clk);
        pixel_x = t.x; pixel_y = t.y; pixel_valid = t.v; start_of_frame = t.sof;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        pixel_valid = 1'b0; start_of_frame = 1'b0;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s scoreboard underflow", name);
        end else begin
            e = exp_q.pop_front();
            check(name, e);
        end
        last = t;
    endtask

    initial begin
        vec_t t;
        // Table: first board line, an idle hold, frame restart, and a mid-frame entry that must stay dark.
        for (int x = 64; x <= 97; x++) begin
            t = exp_at(x, 32); t.chk_sync = 1'b1;
            tbl.push_back(t);
            if (x == 80) begin
                t.x = 11'd500; t.v = 1'b0;   // no valid: outputs hold
                tbl.push_back(t);
            end
        end
        t = blank(64, 32, 1'b1, 1'b1); t.chk_sync = 1'b1; tbl.push_back(t);  // sof beats valid
        tbl.push_back(blank(70, 32, 1'b1, 1'b0));
        tbl.push_back(blank(64, 33, 1'b1, 1'b0));
        tbl.push_back(exp_at(64, 32));

        #12;
        check("reset", blank(0, 0, 1'b0, 1'b0));
        total++;
        if (sync_error !== 1'b0) begin
            bad++; $display("FAIL reset_sync got=%b want=0", sync_error);
        end
        @(negedge clk); rst_n = 1'b1;

        foreach (tbl[i]) drive($sformatf("tbl%0d", i), tbl[i]);

        // Skipped pixel raises a sticky sync_error until the next frame start.
        drive("sof5", blank(0, 0, 1'b0, 1'b1));
        for (int x = 64; x <= 100; x++) drive("run5", exp_at(x, 32));
        t = exp_at(102, 32); t.ox = 11'd0; t.ins = 1'b0; t.col = 6'd0; t.oy = 11'd0;
        t = exp_at(101, 32); t.x = 11'd102; t.sync = 1'b1; t.chk_sync = 1'b1;
        drive("skip", t);
        for (int i = 0; i < 3; i++) begin
            t = last; t.v = 1'b0; drive("sync_hold", t);
        end
        t = blank(0, 0, 1'b0, 1'b1); t.chk_sync = 1'b1;
        drive("sync_clr", t);

        // Row sweep: one left-edge pixel per line, a full board line at y=64, bottom edge, next frame.
        for (int y = 32; y <= 416; y++) begin
            drive("row", exp_at(64, y));
            if (y == 64)
                for (int x = 65; x <= 577; x++) drive("right_edge", exp_at(x, 64));
        end
        drive("sof_new", blank(0, 0, 1'b0, 1'b1));
        drive("new_frame", exp_at(64, 32));

        // Grid-gap corner: second line, crossing into column 1.
        drive("sof6", blank(0, 0, 1'b0, 1'b1));
        drive("gap_l0", exp_at(64, 32));
        for (int x = 64; x <= 97; x++) drive("gap_l1", exp_at(x, 33));
`ifdef GRID_GAP_EN
        total++;
        if (inside_rectangle !== 1'b1 || offset_x !== 11'd1 || offset_y !== 11'd1 || cell_col !== 6'd1) begin
            bad++; $display("FAIL gap_97 got ins=%b off=(%0d,%0d) col=%0d want 1 (1,1) 1",
                            inside_rectangle, offset_x, offset_y, cell_col);
        end
`endif

        // Reset mid-line: nothing lights up until the top line is seen again.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        drive("rst_mid0", blank(80, 40, 1'b1, 1'b0));
        drive("rst_mid1", blank(81, 40, 1'b1, 1'b0));
        drive("rst_mid2", blank(64, 41, 1'b1, 1'b0));
        drive("rst_mid3", blank(65, 41, 1'b1, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
